adc_cfg_sequencer: RTL and testbench
====================================

// Module: adc_cfg_sequencer
// PURPOSE
//  Avalon-MM master that programs the ADC interface register bank (addr 0..7) at bring-up.
//  Walks a fixed table of {address, data} entries, issuing one single-cycle write per entry.
//  Optionally reads each register back and compares it against the value written.
//  Sits between the top-level start/status logic and the ADC interface slave port, on main_clk.
// PARAMETERS
//  NUM_ENTRIES   8  table length, 1..16; entries 0..NUM_ENTRIES-1 executed in order
//  READ_LATENCY  1  cycles from the read-pulse edge to readdata valid at the slave, 1..4
//  GAP_CYCLES    1  idle cycles with write=read=0 between bus transactions, 0..7
// PORTS
//  main_clk   in   1  system clock; all logic on rising edge
//  reset      in   1  synchronous, active-high
//  start      in   1  level; sampled in IDLE/DONE/ERROR; a 1 starts a pass from entry 0
//  address    out  4  Avalon-MM address
//  write      out  1  Avalon-MM write strobe, 1-cycle pulse
//  writedata  out  8  Avalon-MM write data
//  read       out  1  Avalon-MM read strobe, 1-cycle pulse
//  readdata   in   8  Avalon-MM read data
//  busy       out  1  high from the first cycle after start is accepted until DONE/ERROR
//  done       out  1  high in DONE; cleared when the next pass is accepted
//  error      out  1  high in ERROR (readback mismatch); cleared when the next pass is accepted
//  err_index  out  4  index of the first failing entry; 0 unless error=1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, entry index 0. Reset asserted mid-pass aborts the pass.
//  On the next edge, write and read drop to 0. No partial transaction is completed.
//  FSM: IDLE -> WR -> GAP -> [RD -> WAIT -> CHK] -> NEXT -> WR ... -> DONE | ERROR.
//   IDLE/DONE/ERROR: on start=1, index<=0, busy<=1, done<=0, error<=0, go to WR.
//   WR:   exactly one cycle. write=1, address=tbl_addr[index], writedata=tbl_data[index].
//   GAP:  GAP_CYCLES cycles with write=read=0. With GAP_CYCLES=0, GAP is skipped.
//   RD:   exactly one cycle. read=1, address=tbl_addr[index]. address holds until CHK.
//   WAIT: READ_LATENCY-1 cycles. readdata is captured on the edge READ_LATENCY cycles after RD.
//   CHK:  if captured==tbl_data[index], go to NEXT. Otherwise err_index<=index, busy<=0, error<=1, go to ERROR.
//   NEXT: if index==NUM_ENTRIES-1, busy<=0, done<=1, go to DONE. Otherwise index++ and go to WR.
//  write and read are never high in the same cycle. Each is high for at most 1 consecutive cycle.
//  start held high through DONE re-runs the pass immediately. start while busy is ignored.
//  Index counter is 4 bits and never wraps past NUM_ENTRIES-1.
//  Outputs are registered. No combinational path exists from readdata or start to any output.
// CONFIGURATION
//  READBACK_VERIFY_EN defined: the RD/WAIT/CHK states exist and error/err_index are live.
//   Total cycles per entry = 1 + GAP_CYCLES + 1 + READ_LATENCY + 1.
//  READBACK_VERIFY_EN undefined: GAP goes straight to NEXT, and read is tied 0.
//   error and err_index are tied 0. Total cycles per entry = 1 + GAP_CYCLES + 1.
// STRUCTURE
//  Package adc_cfg_pkg holds:
//   - the FSM state encoding constants;
//   - register address constants REG_CTRL=0 .. REG_MON=7;
//   - the default table values.
//  Sub-module adc_cfg_table: combinational lookup index[3:0] -> {addr[3:0], data[7:0]}.
//   Default contents: 0:0xAA 1:0x01 2:0x02 3:0x02 4:0x02 5:0x01 6:0x01 7:0x01, with addr = index.
//  Sequencer FSM, gap/latency counter and index counter live in adc_cfg_sequencer.
// TESTING
//  1. Reset for 3 cycles, then start=1 for 1 cycle, with a slave model that echoes writes.
//     Expect 8 write pulses in the order addr 0..7 with data AA,01,02,02,02,01,01,01, then done=1, busy=0, error=0.
//  2. Slave forces reg 3 to read back 0x00.
//     Expect error=1, err_index=3, and no write to addr 4.
//  3. READ_LATENCY=3, GAP_CYCLES=0.
//     Expect capture exactly 3 cycles after each read pulse and 6 cycles per entry. The pass completes cleanly.
//  4. Assert reset during the WR of entry 5.
//     Expect write=0 on the next cycle and all outputs 0. A fresh start begins again at addr 0.
//  5. Pulse start while busy, then hold start=1 across DONE.
//     Expect the first pulse ignored. DONE then lasts 1 cycle and a second pass begins at addr 0.
//  6. Build without READBACK_VERIFY_EN.
//     Expect read never asserted, 3 cycles per entry at GAP_CYCLES=1, and error stuck at 0.

Source files
------------

// File: rtl/adc_cfg_pkg.sv
// Shared definitions for the ADC configuration sequencer: FSM state
// encoding, ADC interface register map and the default bring-up table.
package adc_cfg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_WR    = 4'd1,
      ST_GAP   = 4'd2,
      ST_RD    = 4'd3,
      ST_WAIT  = 4'd4,
      ST_CHK   = 4'd5,
      ST_NEXT  = 4'd6,
      ST_DONE  = 4'd7,
      ST_ERROR = 4'd8
   } state_t;

   localparam logic [3:0] REG_CTRL   = 4'd0;
   localparam logic [3:0] REG_GAIN   = 4'd1;
   localparam logic [3:0] REG_OFFSET = 4'd2;
   localparam logic [3:0] REG_CLKDIV = 4'd3;
   localparam logic [3:0] REG_MODE   = 4'd4;
   localparam logic [3:0] REG_CHEN   = 4'd5;
   localparam logic [3:0] REG_TEST   = 4'd6;
   localparam logic [3:0] REG_MON    = 4'd7;

   localparam logic [7:0] DEF_CTRL   = 8'hAA;
   localparam logic [7:0] DEF_GAIN   = 8'h01;
   localparam logic [7:0] DEF_OFFSET = 8'h02;
   localparam logic [7:0] DEF_CLKDIV = 8'h02;
   localparam logic [7:0] DEF_MODE   = 8'h02;
   localparam logic [7:0] DEF_CHEN   = 8'h01;
   localparam logic [7:0] DEF_TEST   = 8'h01;
   localparam logic [7:0] DEF_MON    = 8'h01;

   // Default write data for a table slot; slots beyond the register bank write 0.
   function automatic logic [7:0] default_data(input logic [3:0] idx);
      logic [7:0] val;
      case (idx)
         REG_CTRL:   val = DEF_CTRL;
         REG_GAIN:   val = DEF_GAIN;
         REG_OFFSET: val = DEF_OFFSET;
         REG_CLKDIV: val = DEF_CLKDIV;
         REG_MODE:   val = DEF_MODE;
         REG_CHEN:   val = DEF_CHEN;
         REG_TEST:   val = DEF_TEST;
         REG_MON:    val = DEF_MON;
         default:    val = 8'h00;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/adc_cfg_table.sv
// Bring-up table: combinational index -> {address, data} lookup.
module adc_cfg_table
   import adc_cfg_pkg::*;
(
   input  logic [3:0] index,
   output logic [3:0] addr,
   output logic [7:0] data
);

   // Each entry targets the register whose address equals its index.
   always_comb begin
      addr = index;
      data = default_data(index);
   end

endmodule

// File: rtl/adc_cfg_sequencer.sv
// Avalon-MM master that walks the bring-up table and writes each entry into
// the ADC interface register bank. Define READBACK_VERIFY_EN to read every
// register back after writing it and stop with error/err_index on mismatch.
module adc_cfg_sequencer
   import adc_cfg_pkg::*;
#(
   parameter int NUM_ENTRIES  = 8,
   parameter int READ_LATENCY = 1,
   parameter int GAP_CYCLES   = 1
)(
   input  logic       main_clk,
   input  logic       reset,
   input  logic       start,
   output logic [3:0] address,
   output logic       write,
   output logic [7:0] writedata,
   output logic       read,
   input  logic [7:0] readdata,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] err_index
);

   localparam logic [3:0] LAST_INDEX = 4'(NUM_ENTRIES - 1);

   state_t     state_q, state_d;
   logic [3:0] index_q, index_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] address_q, address_d;
   logic       write_q, write_d;
   logic [7:0] writedata_q, writedata_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       gap_done;
   logic [3:0] tbl_addr;
   logic [7:0] tbl_data;
`ifdef READBACK_VERIFY_EN
   logic       read_q, read_d;
   logic       error_q, error_d;
   logic [3:0] err_index_q, err_index_d;
   logic [7:0] capt_q, capt_d;
`else
   logic       unused_readdata;
   assign unused_readdata = ^readdata;
`endif

   // The table is addressed by the next index so write data is registered
   // together with the WR state it belongs to.
   adc_cfg_table u_table (
      .index (index_d),
      .addr  (tbl_addr),
      .data  (tbl_data)
   );

   // Entry index: cleared when a pass is accepted, advanced in NEXT, never past the last entry.
   always_comb begin
      index_d = index_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: if (start) index_d = 4'd0;
         ST_NEXT: if (index_q != LAST_INDEX) index_d = index_q + 4'd1;
         default: ;
      endcase
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      address_d   = address_q;
      write_d     = 1'b0;
      writedata_d = writedata_q;
      busy_d      = busy_q;
      done_d      = done_q;
      gap_done    = 1'b0;
`ifdef READBACK_VERIFY_EN
      read_d      = 1'b0;
      error_d     = error_q;
      err_index_d = err_index_q;
      capt_d      = capt_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               busy_d      = 1'b1;
               done_d      = 1'b0;
`ifdef READBACK_VERIFY_EN
               error_d     = 1'b0;
               err_index_d = 4'd0;
`endif
               state_d     = ST_WR;
               write_d     = 1'b1;
               address_d   = tbl_addr;
               writedata_d = tbl_data;
            end
         end
         ST_WR: begin
            if (GAP_CYCLES > 0) begin
               state_d = ST_GAP;
               cnt_d   = 3'(GAP_CYCLES - 1);
            end else begin
               gap_done = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == 3'd0) gap_done = 1'b1;
            else               cnt_d = cnt_q - 3'd1;
         end
`ifdef READBACK_VERIFY_EN
         ST_RD: begin
            if (READ_LATENCY == 1) begin
               state_d = ST_CHK;
               capt_d  = readdata;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = 3'(READ_LATENCY - 2);
            end
         end
         ST_WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = ST_CHK;
               capt_d  = readdata;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_CHK: begin
            if (capt_q == tbl_data) begin
               state_d = ST_NEXT;
            end else begin
               err_index_d = index_q;
               busy_d      = 1'b0;
               error_d     = 1'b1;
               state_d     = ST_ERROR;
            end
         end
`endif
         ST_NEXT: begin
            if (index_q == LAST_INDEX) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d     = ST_WR;
               write_d     = 1'b1;
               address_d   = tbl_addr;
               writedata_d = tbl_data;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Leaving the gap: read back the same address, or move on when not verifying.
      if (gap_done) begin
`ifdef READBACK_VERIFY_EN
         state_d = ST_RD;
         read_d  = 1'b1;
`else
         state_d = ST_NEXT;
`endif
      end
   end

   // State and registered outputs; reset aborts any pass in progress.
   always_ff @(posedge main_clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         index_q     <= 4'd0;
         cnt_q       <= 3'd0;
         address_q   <= 4'd0;
         write_q     <= 1'b0;
         writedata_q <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef READBACK_VERIFY_EN
         read_q      <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= 4'd0;
         capt_q      <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         cnt_q       <= cnt_d;
         address_q   <= address_d;
         write_q     <= write_d;
         writedata_q <= writedata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef READBACK_VERIFY_EN
         read_q      <= read_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
         capt_q      <= capt_d;
`endif
      end
   end

   assign address   = address_q;
   assign write     = write_q;
   assign writedata = writedata_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef READBACK_VERIFY_EN
   assign read      = read_q;
   assign error     = error_q;
   assign err_index = err_index_q;
`else
   assign read      = 1'b0;
   assign error     = 1'b0;
   assign err_index = 4'd0;
`endif

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Testbench for adc_cfg_sequencer. Two instances: dut 0 with READ_LATENCY=1,
// GAP_CYCLES=1 and dut 1 with READ_LATENCY=3, GAP_CYCLES=0. Each has a slave
// model that echoes writes and presents readdata only in the single cycle
// ending on the expected capture edge. Expectations follow READBACK_VERIFY_EN.
module tb_adc_cfg_sequencer;
`ifdef READBACK_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int N = 8;
   localparam logic [7:0] DEF [8] = '{8'hAA, 8'h01, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01};

   typedef struct { int cyc; int addr; int data; } ev_t;
   typedef struct {
      int d; bit corrupt; int ca; logic [7:0] cv;
      bit exp_done; bit exp_error; int exp_idx;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       start_s     [2];
   logic [3:0] address_s   [2];
   logic       write_s     [2];
   logic [7:0] writedata_s [2];
   logic       read_s      [2];
   logic [7:0] readdata_s  [2];
   logic       busy_s      [2];
   logic       done_s      [2];
   logic       error_s     [2];
   logic [3:0] err_index_s [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   ev_t        wr_q [2][$];
   ev_t        rd_q [2][$];
   int         viol    [2] = '{0, 0};
   int         due     [2] = '{-100, -100};
   logic [3:0] rd_addr [2];
   bit         prev_wr [2] = '{0, 0};
   bit         prev_rd [2] = '{0, 0};
   logic [7:0] mem     [2][16];
   bit         c_en    [2] = '{0, 0};
   logic [3:0] c_addr  [2] = '{4'd0, 4'd0};
   logic [7:0] c_val   [2] = '{8'd0, 8'd0};
   ev_t        ev;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      adc_cfg_sequencer #(
         .NUM_ENTRIES  (N),
         .READ_LATENCY ((gi == 0) ? 1 : 3),
         .GAP_CYCLES   ((gi == 0) ? 1 : 0)
      ) u_dut (
         .main_clk  (clk),
         .reset     (rst),
         .start     (start_s[gi]),
         .address   (address_s[gi]),
         .write     (write_s[gi]),
         .writedata (writedata_s[gi]),
         .read      (read_s[gi]),
         .readdata  (readdata_s[gi]),
         .busy      (busy_s[gi]),
         .done      (done_s[gi]),
         .error     (error_s[gi]),
         .err_index (err_index_s[gi])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic int gap_of(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   function automatic int period_of(input int d);
      return VERIFY ? (3 + gap_of(d) + lat_of(d)) : (2 + gap_of(d));
   endfunction

   function automatic int key(input int off, input int addr, input int data);
      return (off << 12) | (addr << 8) | data;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor, protocol watch and slave model, all sampled mid-cycle.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (write_s[d] === 1'b1) begin
            ev.cyc = cyc; ev.addr = int'(address_s[d]); ev.data = int'(writedata_s[d]);
            wr_q[d].push_back(ev);
            mem[d][address_s[d]] = writedata_s[d];
         end
         if (read_s[d] === 1'b1) begin
            ev.cyc = cyc; ev.addr = int'(address_s[d]); ev.data = 0;
            rd_q[d].push_back(ev);
            due[d]     = cyc + lat_of(d) - 1;
            rd_addr[d] = address_s[d];
         end
         if (write_s[d] === 1'b1 && read_s[d] === 1'b1) viol[d]++;
         if (write_s[d] === 1'b1 && prev_wr[d]) viol[d]++;
         if (read_s[d] === 1'b1 && prev_rd[d]) viol[d]++;
         if (!VERIFY && read_s[d] === 1'b1) viol[d]++;
         if (!VERIFY && error_s[d] === 1'b1) viol[d]++;
         if (error_s[d] === 1'b0 && err_index_s[d] !== 4'd0) viol[d]++;
         prev_wr[d] = (write_s[d] === 1'b1);
         prev_rd[d] = (read_s[d] === 1'b1);
         if (cyc == due[d])
            readdata_s[d] = (c_en[d] && rd_addr[d] == c_addr[d]) ? c_val[d] : mem[d][rd_addr[d]];
         else
            readdata_s[d] = 8'hEE;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input int d, input string name);
      check($sformatf("%s_d%0d", name, d),
            {address_s[d], write_s[d], writedata_s[d], read_s[d], busy_s[d],
             done_s[d], error_s[d], err_index_s[d]}, 64'd0);
   endtask

   // One full pass on dut d, checked against the transaction schedule the rules imply.
   task automatic run_pass(input int d, input bit corrupt, input int ca, input logic [7:0] cv,
                           output bit got_done, output bit got_err, output int got_idx);
      int  c0, p, g, wr_base, rd_base, vbase, n_wr, n_rd, end_off, fin;
      bit  fails;
      g       = gap_of(d);
      p       = period_of(d);
      fails   = VERIFY && corrupt && (cv != DEF[ca]);
      n_wr    = fails ? ca + 1 : N;
      n_rd    = VERIFY ? n_wr : 0;
      end_off = 1 + (fails ? (ca * p + p - 1) : (N * p));
      c_en[d] = corrupt; c_addr[d] = 4'(ca); c_val[d] = cv;
      @(negedge clk);
      wr_base = wr_q[d].size(); rd_base = rd_q[d].size(); vbase = viol[d];
      start_s[d] = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start_s[d] = 1'b0;
      fin = -1;
      for (int k = 0; k < 400 && fin < 0; k++) begin
         @(negedge clk);
         if (busy_s[d] === 1'b0 && (done_s[d] === 1'b1 || error_s[d] === 1'b1)) fin = cyc;
      end
      check($sformatf("d%0d_finish_off", d), fin - c0, end_off);
      check($sformatf("d%0d_write_count", d), wr_q[d].size() - wr_base, n_wr);
      for (int i = 0; i < n_wr && wr_base + i < wr_q[d].size(); i++) begin
         ev_t e;
         e = wr_q[d][wr_base + i];
         check($sformatf("d%0d_write%0d_{off,addr,data}", d, i),
               key(e.cyc - c0, e.addr, e.data), key(1 + i * p, i, int'(DEF[i])));
      end
      check($sformatf("d%0d_read_count", d), rd_q[d].size() - rd_base, n_rd);
      for (int i = 0; i < n_rd && rd_base + i < rd_q[d].size(); i++) begin
         ev_t e;
         e = rd_q[d][rd_base + i];
         check($sformatf("d%0d_read%0d_{off,addr}", d, i),
               key(e.cyc - c0, e.addr, 0), key(2 + i * p + g, i, 0));
      end
      check($sformatf("d%0d_busy", d), busy_s[d], 0);
      check($sformatf("d%0d_done", d), done_s[d], !fails);
      check($sformatf("d%0d_error", d), error_s[d], fails);
      check($sformatf("d%0d_err_index", d), err_index_s[d], fails ? ca : 0);
      check($sformatf("d%0d_protocol", d), viol[d] - vbase, 0);
      got_done = (done_s[d] === 1'b1);
      got_err  = (error_s[d] === 1'b1);
      got_idx  = int'(err_index_s[d]);
      $display("[TB] pass dut=%0d corrupt=%0d reg=%0d val=%02h -> writes=%0d reads=%0d done=%0d error=%0d err_index=%0d",
               d, corrupt, ca, cv, wr_q[d].size() - wr_base, rd_q[d].size() - rd_base,
               got_done, got_err, got_idx);
   endtask

   initial begin
      vec_t vecs [5];
      bit   gd, ge;
      int   gi_idx, c0, p, dcyc, wr_base, vbase, found, fin;

      vecs[0] = '{0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0};
      vecs[1] = '{0, 1'b1, 3, 8'h00, !VERIFY, VERIFY, VERIFY ? 3 : 0};
      vecs[2] = '{1, 1'b0, 0, 8'h00, 1'b1, 1'b0, 0};
      vecs[3] = '{1, 1'b1, 7, 8'h55, !VERIFY, VERIFY, VERIFY ? 7 : 0};
      vecs[4] = '{0, 1'b1, 0, 8'hAA, 1'b1, 1'b0, 0};

      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         for (int a = 0; a < 16; a++) mem[d][a] = 8'h00;
      end

      // Reset held for three cycles: every output must be 0.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle(0, "reset_state");
      check_idle(1, "reset_state");
      rst = 1'b0;

      // Table-driven passes.
      for (int v = 0; v < 5; v++) begin
         run_pass(vecs[v].d, vecs[v].corrupt, vecs[v].ca, vecs[v].cv, gd, ge, gi_idx);
         check($sformatf("vec%0d_outcome", v), {gd, ge, 4'(gi_idx)},
               {vecs[v].exp_done, vecs[v].exp_error, 4'(vecs[v].exp_idx)});
      end

      // Randomized passes against the schedule model.
      for (int r = 0; r < 8; r++) begin
         run_pass(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  8'($urandom), gd, ge, gi_idx);
      end

      // Reset during the WR of entry 5 aborts the pass.
      c_en[0] = 1'b0;
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      found = 0;
      for (int k = 0; k < 300 && found == 0; k++) begin
         @(negedge clk);
         if (write_s[0] === 1'b1 && address_s[0] === 4'd5) found = 1;
      end
      check("midreset_reached_entry5", found, 1);
      rst = 1'b1;
      @(negedge clk);
      check_idle(0, "midreset_outputs");
      rst = 1'b0;
      run_pass(0, 1'b0, 0, 8'h00, gd, ge, gi_idx);

      // Start pulse while busy is ignored; start held through DONE re-runs at once.
      c_en[0] = 1'b0;
      p = period_of(0);
      @(negedge clk);
      wr_base = wr_q[0].size(); vbase = viol[0];
      start_s[0] = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (6) @(negedge clk);
      start_s[0] = 1'b1;
      dcyc = c0 + 1 + N * p;
      for (int k = 0; k < 400 && cyc < dcyc; k++) @(negedge clk);
      check("hold_done_cycle", cyc - c0, dcyc - c0);
      check("hold_done_state_{busy,done}", {busy_s[0], done_s[0]}, 2'b01);
      @(negedge clk);
      check("hold_rerun_{busy,done,write,addr}",
            {busy_s[0], done_s[0], write_s[0], address_s[0]}, 7'b1010000);
      start_s[0] = 1'b0;
      fin = 0;
      for (int k = 0; k < 400 && fin == 0; k++) begin
         @(negedge clk);
         if (busy_s[0] === 1'b0 && done_s[0] === 1'b1) fin = 1;
      end
      check("hold_second_pass_done", fin, 1);
      check("hold_write_count", wr_q[0].size() - wr_base, 2 * N);
      for (int i = 0; i < 2 * N && wr_base + i < wr_q[0].size(); i++) begin
         ev_t e;
         int  exp_cyc;
         e = wr_q[0][wr_base + i];
         exp_cyc = (i < N) ? (c0 + 1 + i * p) : (dcyc + 1 + (i - N) * p);
         check($sformatf("hold_write%0d_{off,addr,data}", i),
               key(e.cyc - c0, e.addr, e.data), key(exp_cyc - c0, i % N, int'(DEF[i % N])));
      end
      check("hold_protocol", viol[0] - vbase, 0);
      $display("[TB] hold-start sequence: writes=%0d", wr_q[0].size() - wr_base);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
